// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU opcode constants, result-stage state encoding and
//                the overflow-qualification helper used by the flag logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU opcodes
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_NOR = 4'b1100;

    // Skid-buffer occupancy: EMPTY, ONE (main only), FULL (main + skid)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    // Only the adder path produces a meaningful overflow; every other
    // opcode (shifts, logic, SLT, unknown encodings) reports none.
    function automatic logic qualify_ovf(input logic [3:0] op, input logic raw_ovf);
        return ((op == OP_ADD) || (op == OP_SUB)) ? raw_ovf : 1'b0;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_flags.sv
`default_nettype none
// ============================================================================
//  Module      : alu_flags
//  Description : Combinational flag generation for an ALU result:
//                zero, negative (sign bit) and qualified overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_flags
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] result_i,
    input  logic [3:0]       op_i,
    input  logic             ovf_i,
    output logic             zero_o,
    output logic             neg_o,
    output logic             ovf_o
);

    assign zero_o = (result_i == '0);
    assign neg_o  = result_i[WIDTH-1];
    assign ovf_o  = qualify_ovf(op_i, ovf_i);

endmodule : alu_flags
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_stage
//  Description : Two-entry skid buffer registering ALU results and their
//                flags, with a registered in_ready, synchronous flush and a
//                wrapping delivered-result counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [3:0]       in_op,
    input  logic             in_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_op,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    stage_state_e     state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Main entry drives the outputs; skid entry catches the second result
    logic [WIDTH-1:0] main_result_q, main_result_d;
    logic [3:0]       main_op_q, main_op_d;
    logic             main_zero_q, main_zero_d;
    logic             main_neg_q, main_neg_d;
    logic             main_ovf_q, main_ovf_d;

    logic [WIDTH-1:0] skid_result_q, skid_result_d;
    logic [3:0]       skid_op_q, skid_op_d;
    logic             skid_zero_q, skid_zero_d;
    logic             skid_neg_q, skid_neg_d;
    logic             skid_ovf_q, skid_ovf_d;

    logic             w_accept;
    logic             w_deliver;
    logic             w_zero;
    logic             w_neg;
    logic             w_ovf;

    // Flags are evaluated on the incoming result and stored with its entry
    alu_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .result_i (in_result),
        .op_i     (in_op),
        .ovf_i    (in_ovf),
        .zero_o   (w_zero),
        .neg_o    (w_neg),
        .ovf_o    (w_ovf)
    );

    assign out_valid  = (state_q != ST_EMPTY);
    assign in_ready   = in_ready_q;
    assign w_accept   = in_valid && in_ready_q;
    assign w_deliver  = out_valid && out_ready;

    assign out_result = main_result_q;
    assign out_op     = main_op_q;
    assign out_zero   = main_zero_q;
    assign out_neg    = main_neg_q;
    assign out_ovf    = main_ovf_q;
    assign out_count  = count_q;

    // Next-state, entry movement and counter update
    always_comb begin
        state_d       = state_q;
        main_result_d = main_result_q;
        main_op_d     = main_op_q;
        main_zero_d   = main_zero_q;
        main_neg_d    = main_neg_q;
        main_ovf_d    = main_ovf_q;
        skid_result_d = skid_result_q;
        skid_op_d     = skid_op_q;
        skid_zero_d   = skid_zero_q;
        skid_neg_d    = skid_neg_q;
        skid_ovf_d    = skid_ovf_q;

        case (state_q)
            ST_EMPTY: begin
                if (w_accept) begin
                    state_d       = ST_ONE;
                    main_result_d = in_result;
                    main_op_d     = in_op;
                    main_zero_d   = w_zero;
                    main_neg_d    = w_neg;
                    main_ovf_d    = w_ovf;
                end
            end
            ST_ONE: begin
                if (w_accept && w_deliver) begin
                    // Main leaves and is replaced in the same edge
                    main_result_d = in_result;
                    main_op_d     = in_op;
                    main_zero_d   = w_zero;
                    main_neg_d    = w_neg;
                    main_ovf_d    = w_ovf;
                end else if (w_accept) begin
                    state_d       = ST_FULL;
                    skid_result_d = in_result;
                    skid_op_d     = in_op;
                    skid_zero_d   = w_zero;
                    skid_neg_d    = w_neg;
                    skid_ovf_d    = w_ovf;
                end else if (w_deliver) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a delivery can occur
                if (w_deliver) begin
                    state_d       = ST_ONE;
                    main_result_d = skid_result_q;
                    main_op_d     = skid_op_q;
                    main_zero_d   = skid_zero_q;
                    main_neg_d    = skid_neg_q;
                    main_ovf_d    = skid_ovf_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush discards everything buffered, including a concurrent accept
        if (flush) begin
            state_d = ST_EMPTY;
        end

        // Registered ready: look ahead at the next occupancy
        in_ready_d = (state_d != ST_FULL);

        // A delivery concurrent with flush still happened and is counted
        count_d = count_q + (w_deliver ? CNT_W'(1) : CNT_W'(0));
    end

    // State and data registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_EMPTY;
            in_ready_q    <= 1'b1;
            count_q       <= '0;
            main_result_q <= '0;
            main_op_q     <= '0;
            main_zero_q   <= 1'b1;
            main_neg_q    <= 1'b0;
            main_ovf_q    <= 1'b0;
            skid_result_q <= '0;
            skid_op_q     <= '0;
            skid_zero_q   <= 1'b1;
            skid_neg_q    <= 1'b0;
            skid_ovf_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            count_q       <= count_d;
            main_result_q <= main_result_d;
            main_op_q     <= main_op_d;
            main_zero_q   <= main_zero_d;
            main_neg_q    <= main_neg_d;
            main_ovf_q    <= main_ovf_d;
            skid_result_q <= skid_result_d;
            skid_op_q     <= skid_op_d;
            skid_zero_q   <= skid_zero_d;
            skid_neg_q    <= skid_neg_d;
            skid_ovf_q    <= skid_ovf_d;
        end
    end

endmodule : alu_result_stage
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_result_stage
//  Description : Self-checking bench for alu_result_stage using an
//                expected-result queue filled on accept, drained on delivery.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SRL = 4'b1000;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [3:0]       in_op;
    logic             in_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_op;
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    int               checks;
    int               failures;
    logic [38:0]      sb[$];
    logic [CNT_W-1:0] exp_count;
    int               delivered;

    alu_result_stage #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_op      (in_op),
        .in_ovf     (in_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_ovf    (out_ovf),
        .out_count  (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference flags: independent restatement of the result-stage rules
    function automatic logic [38:0] model(input logic [31:0] res, input logic [3:0] op, input logic ovf);
        logic z, n, o;
        z = (res == 32'h0);
        n = res[31];
        o = ((op == C_ADD) || (op == C_SUB)) ? ovf : 1'b0;
        return {res, op, z, n, o};
    endfunction

    task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] op, input logic ovf);
        in_valid  = v;
        in_result = res;
        in_op     = op;
        in_ovf    = ovf;
    endtask

    // One clock: scoreboard bookkeeping at negedge, then step past posedge
    task automatic tick();
        logic [38:0] e;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_output", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check_eq("sb_data", 64'({out_result, out_op, out_zero, out_neg, out_ovf}), 64'(e));
            end
            exp_count = exp_count + 1'b1;
            delivered++;
        end
        if (!rst && !flush && in_valid && in_ready)
            sb.push_back(model(in_result, in_op, in_ovf));
        if (rst || flush)
            sb.delete();
        if (rst)
            exp_count = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string pfx);
        check_eq({pfx, "_out_valid"},  64'(out_valid),  64'(0));
        check_eq({pfx, "_in_ready"},   64'(in_ready),   64'(1));
        check_eq({pfx, "_out_result"}, 64'(out_result), 64'(0));
        check_eq({pfx, "_out_op"},     64'(out_op),     64'(0));
        check_eq({pfx, "_out_zero"},   64'(out_zero),   64'(1));
        check_eq({pfx, "_out_neg"},    64'(out_neg),    64'(0));
        check_eq({pfx, "_out_ovf"},    64'(out_ovf),    64'(0));
        check_eq({pfx, "_out_count"},  64'(out_count),  64'(0));
    endtask

    // Empty the stage with a bounded number of cycles
    task automatic drain(input string tag);
        drive(1'b0, 32'h0, C_AND, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 8 && out_valid; i++) tick();
        check_eq({tag, "_drained"}, 64'(out_valid), 64'(0));
        check_eq({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
    endtask

    task automatic fill_full();
        out_ready = 1'b0;
        drive(1'b1, 32'h1234_5678, C_ADD, 1'b0);
        tick();
        drive(1'b1, 32'h0000_0009, C_SUB, 1'b1);
        tick();
        drive(1'b0, 32'h0, C_AND, 1'b0);
        check_eq("fill_in_ready_low", 64'(in_ready), 64'(0));
    endtask

    initial begin
        logic [31:0]      hold_res;
        logic [CNT_W-1:0] saved_cnt;
        int               d0;

        checks    = 0;
        failures  = 0;
        exp_count = '0;
        delivered = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, C_AND, 1'b0);

        // Reset
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;

        // Zero result through a shift opcode, raw overflow must be dropped
        drive(1'b1, 32'h0000_0000, C_SRL, 1'b1);
        out_ready = 1'b1;
        tick();
        drive(1'b0, 32'h0, C_AND, 1'b0);
        check_eq("lat1_out_valid", 64'(out_valid), 64'(1));
        check_eq("lat1_out_zero",  64'(out_zero),  64'(1));
        check_eq("lat1_out_ovf",   64'(out_ovf),   64'(0));
        check_eq("lat1_count_pre", 64'(out_count), 64'(0));
        tick();
        check_eq("lat1_count",     64'(out_count), 64'(1));

        // Back-pressure: fill both entries, hold, then release in order
        out_ready = 1'b0;
        drive(1'b1, 32'h8000_0001, C_ADD, 1'b1);
        tick();
        drive(1'b1, 32'h0000_0005, C_AND, 1'b1);
        tick();
        drive(1'b0, 32'h0, C_AND, 1'b0);
        check_eq("full_in_ready",   64'(in_ready),   64'(0));
        check_eq("full_out_result", 64'(out_result), 64'(32'h8000_0001));
        check_eq("full_out_neg",    64'(out_neg),    64'(1));
        check_eq("full_out_ovf",    64'(out_ovf),    64'(1));
        hold_res = out_result;
        tick();
        tick();
        check_eq("stall_hold_result", 64'(out_result), 64'(hold_res));
        check_eq("stall_hold_valid",  64'(out_valid),  64'(1));
        out_ready = 1'b1;
        tick();
        check_eq("skid_to_main", 64'(out_result), 64'(32'h0000_0005));
        check_eq("skid_ovf_qual", 64'(out_ovf), 64'(0));
        tick();
        check_eq("bp_count", 64'(out_count), 64'(exp_count));
        check_eq("bp_count_abs", 64'(out_count), 64'(3));

        // Full-throughput stream of 100 results
        d0 = delivered;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, $urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            tick();
            check_eq("stream_in_ready", 64'(in_ready), 64'(1));
        end
        drive(1'b0, 32'h0, C_AND, 1'b0);
        tick();
        check_eq("stream_delivered", 64'(delivered - d0), 64'(100));
        check_eq("stream_count", 64'(out_count), 64'(exp_count));

        // Random valid/ready mix to exercise every occupancy transition
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain("mix");
        check_eq("mix_count", 64'(out_count), 64'(exp_count));

        // Flush while FULL with a concurrent accept attempt
        fill_full();
        saved_cnt = out_count;
        flush = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF, C_ADD, 1'b1);
        out_ready = 1'b0;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, C_AND, 1'b0);
        check_eq("flush_out_valid", 64'(out_valid), 64'(0));
        check_eq("flush_in_ready",  64'(in_ready),  64'(1));
        check_eq("flush_count",     64'(out_count), 64'(saved_cnt));
        tick();
        check_eq("flush_no_accept", 64'(out_valid), 64'(0));

        // Flush with a concurrent delivery: delivery still counted
        drive(1'b1, 32'h0000_0042, C_OR_FIX(), 1'b0);
        out_ready = 1'b0;
        tick();
        drive(1'b0, 32'h0, C_AND, 1'b0);
        saved_cnt = out_count;
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_dlv_count", 64'(out_count), 64'(saved_cnt + 1'b1));
        check_eq("flush_dlv_valid", 64'(out_valid), 64'(0));

        // Reset overrides flush and handshakes while FULL
        fill_full();
        rst   = 1'b1;
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'hFFFF_FFFF, C_SUB, 1'b1);
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, C_AND, 1'b0);
        check_reset_values("rst_full");

        // Counter wrap: 65535 deliveries, then one more
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, $urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            tick();
        end
        drive(1'b0, 32'h0, C_AND, 1'b0);
        tick();
        check_eq("wrap_ffff", 64'(out_count), 64'(16'hFFFF));
        drive(1'b1, 32'h0000_0001, C_ADD, 1'b0);
        tick();
        drive(1'b0, 32'h0, C_AND, 1'b0);
        tick();
        check_eq("wrap_zero", 64'(out_count), 64'(16'h0000));
        drain("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [3:0] C_OR_FIX();
        return 4'b0001;
    endfunction

endmodule : tb_alu_result_stage
`default_nettype wire

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, width of delivered-result counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  synchronous discard of buffered results.
REQ-006 SHALL have port in_valid  input  1  upstream result (shifter/ALU core) valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept a result this cycle.
REQ-008 SHALL have port in_result  input  WIDTH  raw result from ALU core/shifter.
REQ-009 SHALL have port in_op  input  4  ALU opcode producing in_result.
REQ-010 SHALL have port in_ovf  input  1  raw overflow from adder path.
REQ-011 SHALL have port out_valid  output  1  registered result valid.
REQ-012 SHALL have port out_ready  input  1  downstream consumer accepts.
REQ-013 SHALL have ports out_result (WIDTH), out_op (4)  outputs  registered copies of accepted result and opcode.
REQ-014 SHALL have ports out_zero, out_neg, out_ovf  outputs  1 each  registered flags.
REQ-015 SHALL have port out_count  output  CNT_W  number of results delivered.

Function
REQ-016 SHALL accept input on edge where in_valid && in_ready; deliver on edge where out_valid && out_ready.
REQ-017 SHALL be a 2-entry skid buffer: states EMPTY, ONE (main only), FULL (main + skid).
REQ-018 Transitions: EMPTY-accept->ONE; ONE-accept-only->FULL; ONE-deliver-only->EMPTY; ONE-accept+deliver->ONE (main replaced); FULL-deliver->ONE (skid moves to main); otherwise hold.
REQ-019 in_ready SHALL be a register output, 1 in EMPTY/ONE, 0 in FULL; no combinational path out_ready->in_ready.
REQ-020 Latency SHALL be 1 cycle: result accepted at edge k is on out_* from edge k when buffer was EMPTY.
REQ-021 Ordering SHALL be FIFO; no result dropped or duplicated except by flush/rst.
REQ-022 out_zero SHALL be 1 iff result == 0; out_neg SHALL equal result[WIDTH-1].
REQ-023 out_ovf SHALL equal in_ovf for ADD/SUB, 0 for all other opcodes (shift opcodes SLL/SRL/SRA force 0).
REQ-024 Flags SHALL be computed at accept time and stored with the entry.
REQ-025 out_* data/flags SHALL hold stable while out_valid && !out_ready.
REQ-026 out_count SHALL increment by 1 per delivery, wrapping 2^CNT_W-1 -> 0.
REQ-027 flush SHALL force EMPTY next edge, in_ready=1, out_valid=0; concurrent accept discarded; concurrent delivery still counted; out_count not cleared.
REQ-028 Unknown opcodes SHALL be passed through with out_ovf=0.

Reset
REQ-029 On rst edge: state EMPTY, out_valid=0, in_ready=1, out_result=0, out_op=0, out_zero=1, out_neg=0, out_ovf=0, out_count=0.
REQ-030 rst SHALL override flush and any handshake in the same cycle, including mid-FULL.

Structure
REQ-031 Opcode constants (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SRL 1000, SLL 1001, SRA 1010, NOR 1100) and state encoding SHALL live in shared package alu_pkg.
REQ-032 Flag generation SHALL be one sub-module alu_flags (combinational: result, op, ovf -> zero, neg, ovf).

Verification
REQ-033 Reset then in_valid=1, in_result=0x0000_0000, op=SRL, out_ready=1 -> next cycle out_valid=1, out_zero=1, out_ovf=0, out_count increments next edge.
REQ-034 out_ready=0, push 0x8000_0001 (ADD, ovf=1) then 0x0000_0005 -> FULL, in_ready=0; raise out_ready -> outputs 0x8000_0001 (neg=1, ovf=1) then 0x5, in order.
REQ-035 Continuous in_valid=out_ready=1 for 100 random results -> throughput 1/cycle, in_ready never 0, out_count=100.
REQ-036 FULL, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_count unchanged.
REQ-037 Preload out_count to 0xFFFF via 65535 deliveries, deliver one more -> out_count=0x0000.
REQ-038 rst asserted while FULL and flush=1 -> all REQ-029 values next edge.
